// File: rtl/seg_readback_decoder_if.sv
// Seven-segment display bus: segment pattern plus one-hot digit select.
// Ports: seg_in[6:0] segment pattern, digit_sel[3:0] one-hot digit select.
interface seg_readback_decoder_if;
   logic [6:0] seg_in;
   logic [3:0] digit_sel;

   modport master (output seg_in, output digit_sel);
   modport slave  (input  seg_in, input  digit_sel);
endinterface

// File: rtl/seg_readback_decoder.sv
// Samples the multiplexed 7-seg bus, deglitches, decodes digits, rebuilds HH:MM frames.
// Ports: clk, reset (sync high), bus (slave), digit_live, frame_digits, frame_valid, illegal, sel_error.
module seg_readback_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   seg_readback_decoder_if.slave bus,
   output logic [15:0] digit_live,
   output logic [15:0] frame_digits,
   output logic        frame_valid,
   output logic        illegal,
   output logic        sel_error
);

   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

   logic [3:0]  sel;
   logic [6:0]  seg;
   logic [10:0] pair_q;
   logic [3:0]  hold_q;
   logic [3:0]  hold_d;
   logic [3:0]  mask_q;
   logic [3:0]  mask_d;
   logic [15:0] live_d;
   logic [3:0]  code;
   logic        untabled;
   logic        multi;
   logic        one_hot;
   logic        same;
   logic        capture;

   assign sel = bus.digit_sel;
   assign seg = bus.seg_in;

   always_comb begin
      code     = 4'hB;
      untabled = 1'b0;
      case (seg)
         7'b0111111: code = 4'h0;
         7'b0110000: code = 4'h1;
         7'b1011011: code = 4'h2;
         7'b1001111: code = 4'h3;
         7'b1100110: code = 4'h4;
         7'b1101101: code = 4'h5;
         7'b1111101: code = 4'h6;
         7'b0000111: code = 4'h7;
         7'b1111111: code = 4'h8;
         7'b1101111: code = 4'h9;
         7'b0001000: code = 4'hA;
         7'b1011100: code = 4'hB;
         default:    untabled = 1'b1;
      endcase
   end

   // The registered pair is the previous sample; comparing against it lets
   // the capture land on the same edge that sees the STABLE-th sample.
   always_comb begin
      multi   = |(sel & (sel - 4'd1));
      one_hot = (sel != 4'd0) && !multi;
      same    = (pair_q == {sel, seg});
      hold_d  = 4'd0;
      if (one_hot) begin
         if (!same)
            hold_d = 4'd1;
         else if (hold_q == STABLE)
            hold_d = STABLE;
         else
            hold_d = hold_q + 4'd1;
      end
      // Fires only on the transition into saturation, so once per hold.
      capture = (hold_d == STABLE) && (hold_q != STABLE);
      live_d  = digit_live;
      for (int n = 0; n < 4; n++)
         if (sel[n]) live_d[4*n +: 4] = code;
      mask_d  = mask_q | sel;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pair_q       <= '0;
         hold_q       <= '0;
         mask_q       <= '0;
         digit_live   <= 16'hAAAA;
         frame_digits <= 16'hAAAA;
         frame_valid  <= 1'b0;
         illegal      <= 1'b0;
         sel_error    <= 1'b0;
      end else begin
         pair_q      <= {sel, seg};
         hold_q      <= hold_d;
         frame_valid <= 1'b0;
         illegal     <= 1'b0;
         if (multi)
            sel_error <= 1'b1;
         if (capture) begin
            digit_live <= live_d;
            illegal    <= untabled;
            if (mask_d == 4'b1111) begin
               frame_digits <= live_d;
               frame_valid  <= 1'b1;
               mask_q       <= 4'b0000;
            end else begin
               mask_q <= mask_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_readback_decoder.sv
// Directed self-checking bench for seg_readback_decoder.
// Ports: none; drives the bus interface and checks all outputs.
module tb_seg_readback_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] digit_live;
   logic [15:0] frame_digits;
   logic        frame_valid;
   logic        illegal;
   logic        sel_error;

   int n_chk = 0;
   int n_fail = 0;
   int fv_cnt = 0;
   int ill_cnt = 0;
   int fv_base;
   int ill_base;

   seg_readback_decoder_if bus ();

   seg_readback_decoder #(.STABLE_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus.slave),
      .digit_live   (digit_live),
      .frame_digits (frame_digits),
      .frame_valid  (frame_valid),
      .illegal      (illegal),
      .sel_error    (sel_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_valid === 1'b1) fv_cnt++;
      if (illegal === 1'b1) ill_cnt++;
   end

   typedef struct {
      logic [3:0]  sel;
      logic [6:0]  seg;
      int          n;
      logic [15:0] live;
      logic [15:0] frame;
      logic        fv;
      logic        ill;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [15:0] got,
                      input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] s, input logic [6:0] g,
                        input int n);
      bus.digit_sel = s;
      bus.seg_in    = g;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      drive(4'b0000, 7'b0000000, 1);
      reset = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{4'b0001, 7'b1011011, 3, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0};
      tbl[1]  = '{4'b0001, 7'b1011011, 1, 16'hAAA2, 16'hAAAA, 1'b0, 1'b0};
      tbl[2]  = '{4'b0000, 7'b0000000, 1, 16'hAAA2, 16'hAAAA, 1'b0, 1'b0};
      tbl[3]  = '{4'b0001, 7'b0110000, 5, 16'hAAA1, 16'hAAAA, 1'b0, 1'b0};
      tbl[4]  = '{4'b0000, 7'b0000000, 1, 16'hAAA1, 16'hAAAA, 1'b0, 1'b0};
      tbl[5]  = '{4'b0010, 7'b1011011, 5, 16'hAA21, 16'hAAAA, 1'b0, 1'b0};
      tbl[6]  = '{4'b0000, 7'b0000000, 1, 16'hAA21, 16'hAAAA, 1'b0, 1'b0};
      tbl[7]  = '{4'b0100, 7'b1001111, 5, 16'hA321, 16'hAAAA, 1'b0, 1'b0};
      tbl[8]  = '{4'b0000, 7'b0000000, 1, 16'hA321, 16'hAAAA, 1'b0, 1'b0};
      tbl[9]  = '{4'b1000, 7'b0111111, 4, 16'h0321, 16'h0321, 1'b1, 1'b0};
      tbl[10] = '{4'b1000, 7'b0111111, 1, 16'h0321, 16'h0321, 1'b0, 1'b0};
      tbl[11] = '{4'b0000, 7'b0000000, 1, 16'h0321, 16'h0321, 1'b0, 1'b0};

      // reset state
      reset = 1'b1;
      drive(4'b0000, 7'b0000000, 2);
      chk("rst_live", digit_live, 16'hAAAA);
      chk("rst_frame", frame_digits, 16'hAAAA);
      chk("rst_flags", {13'd0, frame_valid, illegal, sel_error}, 16'h0);
      reset = 1'b0;

      // capture latency and digit scan
      fv_base = fv_cnt;
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].sel, tbl[i].seg, tbl[i].n);
         chk($sformatf("vec%0d_live", i), digit_live, tbl[i].live);
         chk($sformatf("vec%0d_frame", i), frame_digits, tbl[i].frame);
         chk($sformatf("vec%0d_fv", i), {15'd0, frame_valid},
             {15'd0, tbl[i].fv});
         chk($sformatf("vec%0d_ill", i), {15'd0, illegal},
             {15'd0, tbl[i].ill});
      end
      chk("scan_fv_count", 16'(fv_cnt - fv_base), 16'd1);
      chk("scan_err", {15'd0, sel_error}, 16'd0);

      // glitching segments never stay stable long enough
      pulse_reset();
      fv_base  = fv_cnt;
      ill_base = ill_cnt;
      for (int i = 0; i < 5; i++) begin
         drive(4'b0010, 7'b1111111, 2);
         drive(4'b0010, 7'b0110000, 2);
      end
      chk("glitch_live", digit_live, 16'hAAAA);
      chk("glitch_fv", 16'(fv_cnt - fv_base), 16'd0);
      drive(4'b0000, 7'b0000000, 1);

      // untabled pattern
      drive(4'b0100, 7'b0000001, 3);
      chk("ill_early", {15'd0, illegal}, 16'd0);
      drive(4'b0100, 7'b0000001, 1);
      chk("ill_live", digit_live, 16'hABAA);
      chk("ill_pulse", {15'd0, illegal}, 16'd1);
      drive(4'b0100, 7'b0000001, 1);
      chk("ill_drop", {15'd0, illegal}, 16'd0);
      chk("ill_count", 16'(ill_cnt - ill_base), 16'd1);
      drive(4'b0000, 7'b0000000, 1);

      // multi-hot select is sticky
      drive(4'b0011, 7'b0111111, 1);
      chk("selerr_set", {15'd0, sel_error}, 16'd1);
      chk("selerr_nocap", digit_live, 16'hABAA);
      drive(4'b0000, 7'b0000000, 1);
      fv_base = fv_cnt;
      for (int d = 0; d < 4; d++) begin
         drive(4'(1 << d), 7'b1111111, 4);
         drive(4'b0000, 7'b0000000, 1);
      end
      chk("frame8", frame_digits, 16'h8888);
      chk("frame8_fv", 16'(fv_cnt - fv_base), 16'd1);
      chk("selerr_hold1", {15'd0, sel_error}, 16'd1);
      for (int d = 0; d < 4; d++) begin
         drive(4'(1 << d), 7'b1101111, 4);
         drive(4'b0000, 7'b0000000, 1);
      end
      chk("frame9", frame_digits, 16'h9999);
      chk("frame9_fv", 16'(fv_cnt - fv_base), 16'd2);
      chk("selerr_hold2", {15'd0, sel_error}, 16'd1);
      pulse_reset();
      chk("selerr_clr", {15'd0, sel_error}, 16'd0);
      chk("clr_live", digit_live, 16'hAAAA);
      chk("clr_frame", frame_digits, 16'hAAAA);

      // reset discards a partial frame
      drive(4'b0001, 7'b1100110, 4);
      drive(4'b0000, 7'b0000000, 1);
      drive(4'b0010, 7'b1101101, 4);
      drive(4'b0000, 7'b0000000, 1);
      drive(4'b0100, 7'b1111101, 4);
      drive(4'b0000, 7'b0000000, 1);
      chk("part_live", digit_live, 16'hA654);
      pulse_reset();
      chk("part_rst", digit_live, 16'hAAAA);
      fv_base = fv_cnt;
      drive(4'b1000, 7'b0000111, 4);
      drive(4'b0000, 7'b0000000, 1);
      chk("part_d3", digit_live, 16'h7AAA);
      chk("part_frame", frame_digits, 16'hAAAA);
      chk("part_fv", 16'(fv_cnt - fv_base), 16'd0);

      // tabled error code is not illegal
      ill_base = ill_cnt;
      drive(4'b0010, 7'b1011100, 4);
      chk("errcode_live", digit_live, 16'h7ABA);
      chk("errcode_ill", 16'(ill_cnt - ill_base), 16'd0);
      drive(4'b0001, 7'b0001000, 4);
      chk("blankcode_live", digit_live, 16'h7ABA);
      chk("blankcode_fv", 16'(fv_cnt - fv_base), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_readback_decoder.md
Name: seg_readback_decoder

Overview:
- Receive-side counterpart of the digit-to-segment encoder.
- Samples the time-multiplexed 4-digit seven-segment bus (segment pattern plus one-hot digit select) that drives the alarm clock display.
- Filters switching glitches and decodes each stable pattern back to a 4-bit digit code, including the blank and error codes.
- Reassembles complete HH:MM frames for self-check and loopback verification of the display path.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured; legal range 2..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- seg_in  in  7  segment pattern currently on the bus; bit6..bit0 in the encoder's segment bit order
- digit_sel  in  4  one-hot digit select; bit n drives digit n; 4'b0000 = blanking interval
- digit_live  out  16  most recent capture per digit; digit n at [4n+3:4n]
- frame_digits  out  16  snapshot of all four digits at the last completed frame
- frame_valid  out  1  one-cycle pulse when frame_digits updates
- illegal  out  1  one-cycle pulse when the captured pattern is not in the decode table
- sel_error  out  1  sticky flag: digit_sel was seen with more than one bit set

Behaviour:
- Reset (synchronous): the following hold from the edge after reset=1 and for as long as reset stays high:
  - digit_live = 16'hAAAA, frame_digits = 16'hAAAA
  - frame_valid = 0, illegal = 0, sel_error = 0
  - capture mask = 4'b0000, hold count = 0, input register = 0
- Decode table, bus pattern -> code:
  - 0111111 -> 0, 0110000 -> 1, 1011011 -> 2, 1001111 -> 3, 1100110 -> 4
  - 1101101 -> 5, 1111101 -> 6, 0000111 -> 7, 1111111 -> 8, 1101111 -> 9
  - 0001000 -> A (blank), 1011100 -> B (error)
  - Any other pattern -> B, and illegal pulses.
- Sampling, every edge:
  - The pair {digit_sel, seg_in} is registered.
  - Hold count h = number of consecutive edges on which the same pair was sampled with digit_sel one-hot.
  - A changed pair gives h = 1 (if one-hot).
  - digit_sel = 0000 or non-one-hot gives h = 0.
  - h saturates at STABLE_CYCLES.
- Capture:
  - Fires once per hold period, on the edge where h reaches STABLE_CYCLES.
  - Example, STABLE_CYCLES = 4: inputs stable at edges 1..4 -> digit_live is updated after edge 4.
  - Loads the decoded code into the selected digit nibble and sets that digit's mask bit.
  - No re-capture while the pair stays unchanged.
- Re-capture of a digit whose mask bit is already set overwrites the nibble; the mask is unchanged.
- Frame completion:
  - On the capture edge that makes the mask 4'b1111, frame_digits loads digit_live including the new nibble.
  - frame_valid = 1 for exactly one cycle.
  - The mask clears to 0000 on the same edge.
- illegal: asserted for one cycle, coincident with the digit_live update of an untabled pattern.
- sel_error:
  - Set on any edge where digit_sel has two or more bits set; cleared only by reset.
  - That sample produces no capture and resets h.
- Blanking (digit_sel = 0000): resets h, no capture; the mask and outputs are retained.
- Reset mid-operation: a partially filled mask is discarded, any pending capture is lost, and outputs return to the reset values.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Reset, then digit_sel = 0001 with seg_in = 1011011 held 4 cycles -> digit_live[3:0] = 2 after edge 4; frame_valid = 0; digit_live[15:4] = AAA.
2. Scan digits 0..3 with patterns for 1, 2, 3, 0 (each held 5 cycles, 1 blank cycle between) -> single frame_valid pulse on the digit-3 capture edge; frame_digits = 16'h0321.
3. digit_sel = 0010 with seg_in toggling 1111111 / 0110000 every 2 cycles for 20 cycles -> no capture; digit_live unchanged at AAAA.
4. digit_sel = 0100 with seg_in = 0000001 held 4 cycles -> digit_live[11:8] = B; illegal pulses exactly 1 cycle.
5. digit_sel = 0011 for 1 cycle, then legal scanning -> sel_error = 1 and remains 1 through subsequent frames until reset.
6. Capture digits 0..2, assert reset for 1 cycle, then capture only digit 3 -> no frame_valid; frame_digits = AAAA.
